regfile_mp: RTL and testbench

Parametrised multi-read-port register file with same-cycle write bypass, a per-register pending-write scoreboard and a self-initialising reset sequence. It is the next-generation general-purpose register file for the CPU datapath. It serves the decode stage (operand reads plus hazard status) and the writeback stage (single write port). Register 0 reads as zero and is never written.

---
 rtl/regfile_mp.sv | 130 +++++++++++++
 tb/tb_regfile_mp.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with same-cycle write bypass, a pending-write
// scoreboard and a self-initialising sweep that loads regs[i] = i after reset.
module regfile_mp #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 5,
  parameter  int NUM_RD = 2,
  parameter  int BYPASS = 1,
  localparam int DEPTH  = 2 ** ADDR_W
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     init_req,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [DEPTH-1:0]         busy_vec
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DEPTH-1:0]    busy_q, busy_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   regs [DEPTH];

  logic                run;
  assign run = (state_q == ST_RUN);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;

    unique case (state_q)
      ST_INIT: begin
        // The init sweep owns the write port; external writes and reserves are ignored.
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = DATA_W'(idx_q);
        idx_d     = idx_q + 1'b1;
        busy_d    = '0;
        if (idx_q == '1) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (init_req) begin
          state_d = ST_INIT;
          idx_d   = '0;
          busy_d  = '0;
        end else begin
          mem_we = wr_en && (wr_addr != '0);
          if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
          end
          // Applied after the clear so a new producer issued this cycle wins.
          if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
          end
          busy_d[0] = 1'b0;
        end
      end

      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
        busy_d  = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // NOTE: the array has no reset; the INIT sweep defines its contents, which
  // keeps it mappable onto plain flop/RAM storage without a reset tree.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      regs[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit  = (BYPASS != 0) && wr_en && (wr_addr == addr);

    assign rd_data[k*DATA_W +: DATA_W] = (!run || addr == '0) ? '0      :
                                         hit                   ? wr_data :
                                                                 regs[addr];
    // Busy comes from the registered scoreboard only, never bypassed.
    assign rd_busy[k] = run & busy_q[addr];
  end

  assign ready    = run;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vectors plus a per-cycle
// comparison of a BYPASS=1 and a BYPASS=0 instance against a behavioural model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DP = 32;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          init_req = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rsv_en = 1'b0;
  logic [AW-1:0] rsv_addr = '0;

  logic             ready_b, ready_n;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_busy_b, rd_busy_n;
  logic [DP-1:0]    busy_vec_b, busy_vec_n;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) u_byp (
    .CLK(CLK), .RST_N(RST_N), .init_req(init_req), .ready(ready_b),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_b)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) u_nob (
    .CLK(CLK), .RST_N(RST_N), .init_req(init_req), .ready(ready_n),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_n)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: an init countdown, an array and a pending set.
  bit          m_run;
  int          m_cnt;
  logic [DW-1:0] m_regs [DP];
  logic [DP-1:0] m_busy;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_run  <= 1'b0;
      m_cnt  <= 0;
      m_busy <= '0;
    end else if (!m_run) begin
      m_regs[m_cnt] <= DW'(m_cnt);
      m_cnt <= m_cnt + 1;
      if (m_cnt == DP - 1) m_run <= 1'b1;
    end else if (init_req) begin
      m_run  <= 1'b0;
      m_cnt  <= 0;
      m_busy <= '0;
    end else begin
      if (wr_en && wr_addr != 0) m_regs[wr_addr] <= wr_data;
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] <= 1'b1;
      else if (wr_en) m_busy[wr_addr] <= 1'b0;
      if (rsv_en && rsv_addr != 0 && wr_en && wr_addr != rsv_addr) m_busy[wr_addr] <= 1'b0;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (!m_run || a == 0) return '0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("cmp ready_b", 64'(ready_b), 64'(m_run));
      check("cmp ready_n", 64'(ready_n), 64'(m_run));
      check("cmp busy_vec_b", 64'(busy_vec_b), 64'(m_busy));
      check("cmp busy_vec_n", 64'(busy_vec_n), 64'(m_busy));
      for (int k = 0; k < NR; k++) begin
        logic [AW-1:0] a;
        a = rd_addr[k*AW +: AW];
        check($sformatf("cmp rd_data_b%0d", k), 64'(rd_data_b[k*DW +: DW]), 64'(exp_rd(a, 1'b1)));
        check($sformatf("cmp rd_data_n%0d", k), 64'(rd_data_n[k*DW +: DW]), 64'(exp_rd(a, 1'b0)));
        check($sformatf("cmp rd_busy_b%0d", k), 64'(rd_busy_b[k]), 64'(m_run & m_busy[a]));
        check($sformatf("cmp rd_busy_n%0d", k), 64'(rd_busy_n[k]), 64'(m_run & m_busy[a]));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; init_req = 1'b0;
  endtask

  task automatic count_init(input string tag);
    for (int e = 1; e <= DP; e++) begin
      tick();
      check($sformatf("%s ready edge %0d", tag, e), 64'(ready_b), 64'(e == DP));
      check($sformatf("%s busy edge %0d", tag, e), 64'(busy_vec_b), 64'd0);
    end
  endtask

  initial begin
    // 1. reset and init sweep
    repeat (3) tick();
    cmp_en = 1'b1;
    #1;
    check("reset ready", 64'(ready_b), 64'd0);
    check("reset busy_vec", 64'(busy_vec_b), 64'd0);
    check("reset rd_data", 64'(rd_data_b), 64'd0);
    RST_N = 1'b1;
    count_init("init");
    rd_addr = {5'd31, 5'd5};
    #1;
    check("init reg5", 64'(rd_data_b[31:0]), 64'd5);
    check("init reg31", 64'(rd_data_b[63:32]), 64'd31);
    check("init busy_vec", 64'(busy_vec_b), 64'd0);

    // 2. bypass vs. no bypass
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd7};
    #1;
    check("bypass same cycle", 64'(rd_data_b[31:0]), 64'hDEADBEEF);
    check("nobypass same cycle", 64'(rd_data_n[31:0]), 64'd7);
    tick(); idle();
    #1;
    check("bypass next cycle", 64'(rd_data_b[31:0]), 64'hDEADBEEF);
    check("nobypass next cycle", 64'(rd_data_n[31:0]), 64'hDEADBEEF);

    // 3. register zero
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr = '0;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1;
    check("reg0 same cycle", 64'(rd_data_b[31:0]), 64'd0);
    tick(); idle();
    #1;
    check("reg0 next cycle", 64'(rd_data_b[31:0]), 64'd0);
    check("reg0 not busy", 64'(busy_vec_b[0]), 64'd0);

    // 4. scoreboard set / set-wins / clear
    rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr = {5'd0, 5'd9};
    #1;
    check("rsv not yet busy", 64'(rd_busy_b[0]), 64'd0);
    tick(); idle();
    #1;
    check("rsv busy_vec9", 64'(busy_vec_b[9]), 64'd1);
    check("rsv rd_busy0", 64'(rd_busy_b[0]), 64'd1);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; rsv_en = 1'b1; rsv_addr = 5'd9;
    tick(); idle();
    #1;
    check("set wins busy9", 64'(busy_vec_b[9]), 64'd1);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h999;
    tick(); idle();
    #1;
    check("clear busy9", 64'(busy_vec_b[9]), 64'd0);
    check("clear rd_busy0", 64'(rd_busy_b[0]), 64'd0);
    check("reg9 data", 64'(rd_data_n[31:0]), 64'h999);

    // 5. soft re-init with a discarded write
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; rsv_en = 1'b1; rsv_addr = 5'd4;
    rd_addr = {5'd6, 5'd3};
    tick(); idle();
    #1;
    check("pre-init reg3", 64'(rd_data_n[31:0]), 64'h55);
    check("pre-init busy4", 64'(busy_vec_b[4]), 64'd1);
    init_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
    tick(); idle();
    #1;
    check("reinit ready low", 64'(ready_b), 64'd0);
    check("reinit busy clear", 64'(busy_vec_b), 64'd0);
    check("reinit rd_data zero", 64'(rd_data_b), 64'd0);
    count_init("reinit");
    #1;
    check("reinit reg3", 64'(rd_data_b[31:0]), 64'd3);
    check("reinit reg6", 64'(rd_data_b[63:32]), 64'd6);

    // 6. reset in the middle of INIT
    init_req = 1'b1;
    tick(); idle();
    repeat (10) tick();
    RST_N = 1'b0;
    #1;
    check("midinit reset ready", 64'(ready_b), 64'd0);
    repeat (2) tick();
    RST_N = 1'b1;
    count_init("midinit");
    for (int i = 0; i < DP; i++) begin
      rd_addr = {5'(DP - 1 - i), 5'(i)};
      #1;
      check($sformatf("final reg%0d", i), 64'(rd_data_b[31:0]), 64'(i));
      check($sformatf("final reg%0d p1", DP - 1 - i), 64'(rd_data_n[63:32]), 64'(DP - 1 - i));
      tick();
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
